// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, instruction field positions and
// per-opcode register-usage decode.
package cpu_pkg;

  typedef enum logic [3:0] {
    NOP     = 4'd0,
    MAX     = 4'd1,
    UNUSED  = 4'd2,
    STORE   = 4'd3,
    ADD     = 4'd4,
    INC     = 4'd5,
    NEG     = 4'd6,
    SUB     = 4'd7,
    J       = 4'd8,
    BRZ     = 4'd9,
    JM      = 4'd10,
    BRN     = 4'd11,
    UNUSED1 = 4'd12,
    UNUSED2 = 4'd13,
    LOAD    = 4'd14,
    SAVE_PC = 4'd15
  } opcode_t;

  localparam int REG_W  = 6;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;
  localparam int RD_MSB = 27;
  localparam int RD_LSB = 22;
  localparam int RS_MSB = 21;
  localparam int RS_LSB = 16;
  localparam int RT_MSB = 15;
  localparam int RT_LSB = 10;

  function automatic logic writes_rd(opcode_t op);
    case (op)
      MAX, ADD, INC, NEG, SUB, LOAD, SAVE_PC: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs(opcode_t op);
    case (op)
      MAX, STORE, ADD, INC, NEG, SUB, J, BRZ, JM, BRN, LOAD: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // SAVE_PC carries an immediate in the rt slot, so it is not listed here.
  function automatic logic reads_rt(opcode_t op);
    case (op)
      MAX, STORE, ADD, SUB: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_stage_hazard_scoreboard.sv
// Tracks destination registers of the last HAZ_DEPTH IF/ID occupants and flags
// a read-after-write conflict for the instruction currently being fetched.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int HAZ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift,
  input  logic             push_v,
  input  logic [REG_W-1:0] push_rd,
  input  logic [REG_W-1:0] src_rs,
  input  logic             src_rs_v,
  input  logic [REG_W-1:0] src_rt,
  input  logic             src_rt_v,
  output logic             hazard
);

  logic             v_reg  [HAZ_DEPTH];
  logic [REG_W-1:0] rd_reg [HAZ_DEPTH];
  logic [HAZ_DEPTH-1:0] match;

  // Entry 0 mirrors IF/ID; older entries age one slot per advancing edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < HAZ_DEPTH; k++) begin
        v_reg[k]  <= 1'b0;
        rd_reg[k] <= '0;
      end
    end else if (shift) begin
      v_reg[0]  <= push_v;
      rd_reg[0] <= push_rd;
      for (int k = 1; k < HAZ_DEPTH; k++) begin
        v_reg[k]  <= v_reg[k-1];
        rd_reg[k] <= rd_reg[k-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < HAZ_DEPTH; gi++) begin : g_match
      assign match[gi] = v_reg[gi] &
                         ((src_rs_v & (rd_reg[gi] == src_rs)) |
                          (src_rt_v & (rd_reg[gi] == src_rt)));
    end
  endgenerate

  assign hazard = |match;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID pipeline register, RAW interlock and
// redirect handling, plus issue/bubble statistics counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter int              HAZ_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic [15:0]     issue_count,
  output logic [15:0]     bubble_count
);

  logic [PC_W-1:0]  pc_reg;
  logic             valid_reg;
  logic [31:0]      instr_reg;
  logic [PC_W-1:0]  if_pc_reg;
  logic [15:0]      issue_reg;
  logic [15:0]      bubble_reg;

  opcode_t          op;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             hazard;
  logic             advance;
  logic             push_v;

  assign op = opcode_t'(imem_rdata[OP_MSB:OP_LSB]);
  assign rd = imem_rdata[RD_MSB:RD_LSB];
  assign rs = imem_rdata[RS_MSB:RS_LSB];
  assign rt = imem_rdata[RT_MSB:RT_LSB];

  // A redirect overrides stall, so the scoreboard ages whenever IF/ID changes.
  assign advance = redirect_valid | ~stall;
  assign push_v  = ~redirect_valid & ~hazard & writes_rd(op);

  hazard_scoreboard #(
    .HAZ_DEPTH(HAZ_DEPTH)
  ) u_sb (
    .clk     (clk),
    .reset_n (reset_n),
    .shift   (advance),
    .push_v  (push_v),
    .push_rd (rd),
    .src_rs  (rs),
    .src_rs_v(reads_rs(op)),
    .src_rt  (rt),
    .src_rt_v(reads_rt(op)),
    .hazard  (hazard)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg     <= RESET_PC;
      valid_reg  <= 1'b0;
      instr_reg  <= '0;
      if_pc_reg  <= '0;
      issue_reg  <= '0;
      bubble_reg <= '0;
    end else if (redirect_valid) begin
      pc_reg    <= redirect_pc;
      valid_reg <= 1'b0;
      instr_reg <= '0;
      if_pc_reg <= '0;
    end else if (!stall) begin
      if (hazard) begin
        valid_reg  <= 1'b0;
        instr_reg  <= '0;
        if_pc_reg  <= '0;
        bubble_reg <= bubble_reg + 16'd1;
      end else begin
        valid_reg <= 1'b1;
        instr_reg <= imem_rdata;
        if_pc_reg <= pc_reg;
        pc_reg    <= pc_reg + PC_W'(1);
        issue_reg <= issue_reg + 16'd1;
      end
    end
  end

  assign imem_addr    = pc_reg;
  assign if_valid     = valid_reg;
  assign if_instr     = instr_reg;
  assign if_pc        = if_pc_reg;
  assign issue_count  = issue_reg;
  assign bubble_count = bubble_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a cycle-count based reference model of the interlock rules.
module tb_fetch_stage;

  localparam int HAZ = 4;

  // Register-usage sets indexed by opcode number.
  localparam logic [15:0] WR_SET = 16'((1<<1)|(1<<4)|(1<<5)|(1<<6)|(1<<7)|(1<<14)|(1<<15));
  localparam logic [15:0] RS_SET = 16'((1<<1)|(1<<3)|(1<<4)|(1<<5)|(1<<6)|(1<<7)|
                                       (1<<8)|(1<<9)|(1<<10)|(1<<11)|(1<<14));
  localparam logic [15:0] RT_SET = 16'((1<<1)|(1<<3)|(1<<4)|(1<<7));

  localparam logic [3:0] T_STORE = 4'd3;
  localparam logic [3:0] T_ADD   = 4'd4;
  localparam logic [3:0] T_SUB   = 4'd7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic [15:0] issue_count;
  logic [15:0] bubble_count;

  logic [31:0] mem [256];
  assign imem_rdata = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage #(.PC_W(8), .HAZ_DEPTH(HAZ), .RESET_PC(8'd0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .issue_count   (issue_count),
    .bubble_count  (bubble_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a register is unreadable until HAZ advancing edges have
  // passed since its producer entered IF/ID.
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [7:0]  m_ifpc;
  logic [15:0] m_issue;
  logic [15:0] m_bubble;
  int          last_write [64];
  int          adv;

  function automatic logic [31:0] mk(logic [3:0] op, int rd, int rs, int rt);
    return {op, 6'(rd), 6'(rs), 6'(rt), 10'h0};
  endfunction

  task automatic model_reset();
    m_pc = 8'd0; m_valid = 1'b0; m_instr = 32'h0; m_ifpc = 8'd0;
    m_issue = 16'd0; m_bubble = 16'd0; adv = 0;
    for (int r = 0; r < 64; r++) last_write[r] = -1000;
  endtask

  task automatic model_bubble();
    m_valid = 1'b0; m_instr = 32'h0; m_ifpc = 8'd0;
  endtask

  task automatic model_step();
    logic [31:0] ins;
    logic [3:0]  op;
    int          rd, rs, rt;
    bit          hz;
    ins = mem[m_pc];
    op = ins[31:28]; rd = int'(ins[27:22]); rs = int'(ins[21:16]); rt = int'(ins[15:10]);
    if (redirect_valid) begin
      adv++;
      m_pc = redirect_pc;
      model_bubble();
    end else if (!stall) begin
      adv++;
      hz = (RS_SET[op] && (adv - last_write[rs] <= HAZ)) ||
           (RT_SET[op] && (adv - last_write[rt] <= HAZ));
      if (hz) begin
        model_bubble();
        m_bubble++;
      end else begin
        m_valid = 1'b1; m_instr = ins; m_ifpc = m_pc;
        m_pc = m_pc + 8'd1;
        m_issue++;
        if (WR_SET[op]) last_write[rd] = adv;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nops();
    for (int a = 0; a < 256; a++) mem[a] = {4'h0, 28'($urandom)};
  endtask

  // Entered 1 time unit after a rising edge; returns still well before the next.
  task automatic do_reset();
    stall = 1'b0; redirect_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1 model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    n_tests++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    n_tests++; if ({issue_count, bubble_count} !== 32'h0) begin n_fail++;
      $display("FAIL reset_counters: got %h/%h want 0/0", issue_count, bubble_count); end
    reset_n = 1'b1;
    tick();
    n_tests++; if ({if_valid, if_pc, issue_count} !== {1'b1, 8'd0, 16'd1}) begin n_fail++;
      $display("FAIL reset_first_fetch: got v=%b pc=%0d iss=%0d want v=1 pc=0 iss=1", if_valid, if_pc, issue_count); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc;
    fill_nops();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 8'd254;
    tick();
    redirect_valid = 1'b0;
    n_tests++; if ({if_valid, if_instr, if_pc} !== 41'h0) begin n_fail++;
      $display("FAIL wrap_redirect_bubble: got v=%b i=%h pc=%0d want 0/0/0", if_valid, if_instr, if_pc); end
    exp_pc = 8'd254;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if ({if_valid, if_pc, if_instr} !== {1'b1, exp_pc, mem[exp_pc]}) begin n_fail++;
        $display("FAIL wrap_step%0d: got v=%b pc=%0d i=%h want v=1 pc=%0d i=%h",
                 i, if_valid, if_pc, if_instr, exp_pc, mem[exp_pc]); end
      exp_pc = exp_pc + 8'd1;
    end
    n_tests++; if ({bubble_count, issue_count, imem_addr} !== {16'd0, 16'd3, 8'd1}) begin n_fail++;
      $display("FAIL wrap_counts: got bub=%0d iss=%0d addr=%0d want 0 3 1", bubble_count, issue_count, imem_addr); end
  endtask

  task automatic test_raw();
    fill_nops();
    mem[0] = mk(T_ADD, 1, 1, 30);
    mem[1] = mk(T_SUB, 2, 1, 3);
    do_reset();
    tick();
    for (int i = 0; i < HAZ; i++) begin
      tick();
      n_tests++; if ({if_valid, imem_addr} !== {1'b0, 8'd1}) begin n_fail++;
        $display("FAIL raw_bubble%0d: got v=%b addr=%0d want v=0 addr=1", i, if_valid, imem_addr); end
    end
    tick();
    n_tests++; if ({if_valid, if_pc, if_instr, bubble_count} !== {1'b1, 8'd1, mem[1], 16'd4}) begin n_fail++;
      $display("FAIL raw_consumer: got v=%b pc=%0d i=%h bub=%0d want v=1 pc=1 i=%h bub=4",
               if_valid, if_pc, if_instr, bubble_count, mem[1]); end
  endtask

  task automatic test_store_no_write();
    fill_nops();
    mem[0] = mk(T_STORE, 0, 5, 4);
    mem[1] = mk(T_ADD, 6, 5, 4);
    do_reset();
    tick();
    tick();
    n_tests++; if ({if_valid, if_pc, bubble_count} !== {1'b1, 8'd1, 16'd0}) begin n_fail++;
      $display("FAIL store_no_hazard: got v=%b pc=%0d bub=%0d want v=1 pc=1 bub=0", if_valid, if_pc, bubble_count); end
  endtask

  task automatic test_redirect_and_stall();
    logic [15:0] iss;
    fill_nops();
    do_reset();
    repeat (8) tick();
    n_tests++; if (if_pc !== 8'd7) begin n_fail++; $display("FAIL redir_pre_pc: got %0d want 7", if_pc); end
    redirect_valid = 1'b1; redirect_pc = 8'd20;
    tick();
    redirect_valid = 1'b0;
    n_tests++; if ({if_valid, if_instr, if_pc} !== 41'h0) begin n_fail++;
      $display("FAIL redir_bubble: got v=%b i=%h pc=%0d want 0/0/0", if_valid, if_instr, if_pc); end
    tick();
    n_tests++; if ({if_valid, if_pc, if_instr, bubble_count} !== {1'b1, 8'd20, mem[20], 16'd0}) begin n_fail++;
      $display("FAIL redir_target: got v=%b pc=%0d i=%h bub=%0d want v=1 pc=20 i=%h bub=0",
               if_valid, if_pc, if_instr, bubble_count, mem[20]); end
    iss = m_issue;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if ({if_valid, if_pc, imem_addr, issue_count, if_instr} !== {1'b1, 8'd20, 8'd21, iss, mem[20]}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b pc=%0d addr=%0d iss=%0d want v=1 pc=20 addr=21 iss=%0d",
                 i, if_valid, if_pc, imem_addr, issue_count, iss); end
    end
    redirect_valid = 1'b1; redirect_pc = 8'd100;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    n_tests++; if ({if_valid, imem_addr} !== {1'b0, 8'd100}) begin n_fail++;
      $display("FAIL stall_redirect: got v=%b addr=%0d want v=0 addr=100", if_valid, imem_addr); end
    tick();
    n_tests++; if ({if_valid, if_pc} !== {1'b1, 8'd100}) begin n_fail++;
      $display("FAIL stall_redirect_target: got v=%b pc=%0d want v=1 pc=100", if_valid, if_pc); end
  endtask

  task automatic test_async_reset();
    fill_nops();
    do_reset();
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if ({imem_addr, if_valid, if_instr, if_pc, issue_count, bubble_count} !== 81'h0) begin n_fail++;
      $display("FAIL async_reset: got addr=%0d v=%b i=%h pc=%0d iss=%0d bub=%0d want all 0",
               imem_addr, if_valid, if_instr, if_pc, issue_count, bubble_count); end
    model_reset();
    #1 reset_n = 1'b1;
    tick();
    n_tests++; if ({if_valid, if_pc, issue_count} !== {1'b1, 8'd0, 16'd1}) begin n_fail++;
      $display("FAIL async_release: got v=%b pc=%0d iss=%0d want v=1 pc=0 iss=1", if_valid, if_pc, issue_count); end
  endtask

  task automatic test_random();
    for (int a = 0; a < 256; a++)
      mem[a] = {4'($urandom_range(0, 15)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                6'($urandom_range(0, 7)), 10'($urandom)};
    do_reset();
    for (int c = 0; c < 600; c++) begin
      stall          = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = 8'($urandom);
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc, imem_addr, issue_count, bubble_count} !==
          {m_valid, m_instr, m_ifpc, m_pc, m_issue, m_bubble}) begin
        n_fail++;
        $display("FAIL random_c%0d: got v=%b i=%h pc=%0d addr=%0d iss=%0d bub=%0d want v=%b i=%h pc=%0d addr=%0d iss=%0d bub=%0d",
                 c, if_valid, if_instr, if_pc, imem_addr, issue_count, bubble_count,
                 m_valid, m_instr, m_ifpc, m_pc, m_issue, m_bubble);
      end
    end
    stall = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_raw();
    test_store_no_write();
    test_redirect_and_stall();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU. Owns the PC, drives the instruction-memory read address, and holds the IF/ID pipeline register that feeds decode. It contains a register-hazard interlock, so programs no longer need four NOPs between a producer and its consumer. It also accepts taken-branch and jump redirects from execute.

## Interface
- PC_W, 8, PC and instruction-memory address width (256 words)
- HAZ_DEPTH, 4, cycles after leaving IF/ID before a result is readable from the register file
- RESET_PC, 0, PC value on reset
- clk  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous and active-low
- imem_addr  out  PC_W  instruction-memory address (current PC)
- imem_rdata  in  32  instruction at imem_addr, combinational read, valid in the same cycle
- stall  in  1  downstream hold
- redirect_valid  in  1  taken branch or jump from execute
- redirect_pc  in  PC_W  redirect target
- if_valid  out  1  IF/ID holds a real instruction (0 means bubble)
- if_instr  out  32  IF/ID instruction
- if_pc  out  PC_W  address of if_instr (consumed by SAVE_PC)
- issue_count  out  16  number of instructions loaded into IF/ID, wraps
- bubble_count  out  16  number of hazard bubbles inserted, wraps

## Operation
- Instruction fields:
  - op = [31:28], rd = [27:22], rs = [21:16], rt = [15:10], [9:0] ignored.
  - All 64 registers are real registers; R0 is not hardwired to zero.
- Opcodes that write rd: MAX, ADD, INC, NEG, SUB, LOAD, SAVE_PC.
- Opcodes that read rs: MAX, STORE, ADD, INC, NEG, SUB, J, BRZ, JM, BRN, LOAD.
- Opcodes that read rt: MAX, STORE, ADD, SUB.
- NOP and the unused opcodes read and write nothing. SAVE_PC's rt field is an immediate, not a register.
- Scoreboard:
  - HAZ_DEPTH entries of {v, rd}.
  - sb[0] mirrors the instruction currently in IF/ID. sb[k] is the instruction that was in IF/ID k cycles earlier.
- hazard = 1 when imem_rdata reads a register equal to sb[k].rd for any k with sb[k].v = 1.
- Per rising edge, evaluated in priority order:
  - redirect_valid: PC <= redirect_pc; IF/ID <= bubble; scoreboard shifts with an invalid entry.
  - else stall: PC, IF/ID, scoreboard and counters all hold.
  - else hazard: PC holds; IF/ID <= bubble; scoreboard shifts with an invalid entry; bubble_count += 1.
  - else: IF/ID <= {1, imem_rdata, PC}; PC <= PC + 1 (wraps 2^PC_W-1 to 0); scoreboard shifts with {writes_rd, rd}; issue_count += 1.
- Bubble encoding: if_valid = 0, if_instr = 32'h0 (NOP), if_pc = 0.
- The redirect squashes only the IF/ID slot. Squashing wrong-path instructions already downstream is decode/execute's job.
- Redirect during stall: the redirect wins, and the PC and IF/ID update as above.
- Redirect during hazard: the redirect wins; bubble_count does not increment.

## Timing
- Reset: imem_addr = RESET_PC, if_valid = 0, if_instr = 0, if_pc = 0, scoreboard all invalid, both counters 0.
  - Asynchronous: outputs clear immediately on reset_n falling, including mid-operation.
- Fetch latency: an instruction at address A appears on if_instr one edge after imem_addr = A with no hazard, redirect or stall.
- Throughput: one instruction per cycle with no hazards.
- RAW spacing: a consumer enters IF/ID exactly HAZ_DEPTH+1 edges after its producer. With the default HAZ_DEPTH, that is 4 bubbles for back-to-back dependence.
- Redirect: target instruction appears in IF/ID 2 edges after redirect_valid is sampled (bubble first, then target).
- The hazard check uses the current imem_rdata and the current scoreboard. There is no combinational path from stall or redirect_valid to imem_addr.

## Structure
- Shared package cpu_pkg contains:
  - opcode_t enum (NOP=0, MAX, UNUSED, STORE, ADD, INC, NEG, SUB, J, BRZ, JM, BRN, UNUSED1, UNUSED2, LOAD, SAVE_PC);
  - field bit-position constants;
  - functions writes_rd(op), reads_rs(op) and reads_rt(op).
- One sub-module, hazard_scoreboard:
  - implements the HAZ_DEPTH shift register and the match logic;
  - inputs: shift, push_v, push_rd, src_rs, src_rs_v, src_rt, src_rt_v;
  - output: hazard.
- fetch_stage contains the PC, IF/ID register, priority logic and counters.

## Test plan
- Reset then release with mem[0..3] = NOP: imem_addr = 0 and if_valid = 0 during reset; on the first edge after release, if_valid = 1, if_pc = 0, issue_count = 1.
- Straight-line NOPs through address 255: if_pc steps 254, 255, 0; no bubbles.
- mem[0] = ADD R1,R1,R30 and mem[1] = SUB R2,R1,R3: 4 bubbles between them, mem[1] in IF/ID 5 edges after mem[0], bubble_count = 4.
- mem[0] = STORE R0,R5,R4 and mem[1] = ADD R6,R5,R4: no bubble, since STORE does not write rd.
- redirect_valid = 1 with redirect_pc = 20 while IF/ID holds pc 7: next IF/ID is a bubble, then if_pc = 20 with instruction mem[20].
- stall held 3 cycles: all outputs frozen. Then redirect and stall together: the redirect is taken.
- Async reset_n pulse mid-run, between edges: outputs and counters clear without waiting for a clock edge.
